apb_uart_fifo: RTL and testbench
================================

Name: apb_uart_fifo

Overview:
- Next-generation APB UART for the krv_m0 peripheral bus: baud generator, TX/RX serialisers and parametrised TX/RX FIFOs in one block.
- Adds what the previous UART lacks: configurable FIFO depth, FIFO level readback, 1/2 stop bits, sticky W1C error flags and a maskable interrupt.
- Sits on the APB3 peripheral fabric; TX/RX go to pads.

Parameters:
FIFO_AW, 4, log2 of TX and RX FIFO depth (depth = 2**FIFO_AW, 1..8)
BAUD_W, 16, width of the baud divisor register (8..16)
BAUD_RST, 0, reset value of the baud divisor

Ports:
PCLK  in  1  system clock; all logic on rising edge
PRESET  in  1  asynchronous, active-high reset
PADDR  in  5  word address, PADDR[4:2] decoded
PSEL  in  1  peripheral select
PENABLE  in  1  access phase
PWRITE  in  1  write/not-read
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
RX  in  1  serial input, asynchronous
TX  out  1  serial output
IRQ  out  1  registered interrupt

Behaviour:
- One clock, PCLK; reset asynchronous active-high (PRESET). On reset: TX=1, IRQ=0, PRDATA=0, FIFOs empty, all registers 0 except BAUD=BAUD_RST.
- Register map; unmapped addresses read 0, writes ignored:
  - 0x00 TXDATA (W): push PWDATA[7:0]. If TX FIFO is full, the data is dropped and TX_OVF is set. Reads as 0.
  - 0x04 RXDATA (R): returns the FIFO head and pops. If RX FIFO is empty, reads 0 and does not pop.
  - 0x08 BAUD (R/W, BAUD_W bits).
  - 0x0C CTRL (R/W): [0] TX_EN, [1] RX_EN, [2] PARITY_EN, [3] ODD, [4] STOP2.
  - 0x10 STATUS: [0] TX_EMPTY, [1] TX_FULL, [2] RX_EMPTY, [3] RX_FULL, [4] RX_OVF, [5] PARITY_ERR, [6] FRAMING_ERR, [7] TX_OVF, [8] TX_BUSY. Bits 4-7 are sticky and write-1-to-clear. If set and clear happen in the same cycle, set wins.
  - 0x14 LEVEL (R): [FIFO_AW:0] TX count, [16+FIFO_AW:16] RX count.
  - 0x18 IRQ_EN (R/W): [0] TX_EMPTY, [1] RX not empty, [2] any sticky error, [3] RX timeout.
- APB: writes take effect on PSEL&PENABLE&PWRITE. PRDATA is registered in the setup phase (PSEL&!PENABLE&!PWRITE) and is valid in the access phase. The RX pop happens in the access phase, one pop per transfer. Zero wait states.
- Baud: down-counter loaded with BAUD. A tick is issued when it reaches 0, then it reloads, giving one tick every BAUD+1 PCLK cycles = 16x oversample. BAUD=0 gives a tick every cycle. Writing BAUD reloads the counter immediately.
- TX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
  - Leaves IDLE when TX_EN=1 and the FIFO is not empty; pops the FIFO on that transition.
  - Each bit lasts 16 ticks. Data is 8 bits, LSB first.
  - PARITY state is skipped if PARITY_EN=0. Parity bit = XOR(data)^ODD.
  - STOP lasts 32 ticks if STOP2=1.
  - TX_EN cleared mid-frame: the current frame completes.
  - TX_BUSY = state != IDLE.
- RX:
  - Two-flop synchroniser, then a falling edge starts the frame.
  - Start bit is re-sampled at tick 8; if it reads 1, return to IDLE (glitch rejected).
  - Data/parity/stop are sampled at mid-bit, every 16 ticks. Only one stop bit is checked.
  - Stop bit = 0 sets FRAMING_ERR; parity mismatch sets PARITY_ERR. The byte is pushed regardless.
  - FIFO full at push: the byte is dropped and RX_OVF is set.
  - RX_EN=0 holds the FSM in IDLE; RX_EN cleared mid-frame aborts the frame without pushing.
- FIFOs: circular buffers with (FIFO_AW+1)-bit pointers; full/empty are taken from the pointer MSB.
  - Push and pop in the same cycle: allowed when neither full nor empty. When full, the push is rejected. When empty, the pop is ignored and the push is accepted.
- IRQ is registered: OR of (source & IRQ_EN), one cycle latency.
- Reset mid-frame: TX goes to 1 immediately (asynchronously).

Optional Feature:
- UART_RX_TIMEOUT_EN defined:
  - 0x1C RXTO (R/W, 8 bits, reset 0).
  - A counter counts bit periods (16 ticks) while the RX FSM is idle and the RX FIFO is not empty. It clears on any push or pop.
  - When the count reaches RXTO (with RXTO≠0), STATUS[9] RX_TIMEOUT is set (sticky, W1C) and feeds IRQ_EN[3].
- UART_RX_TIMEOUT_EN not defined: 0x1C reads 0, STATUS[9]=0, IRQ_EN[3] has no effect; no counter logic is generated.

Test Plan:
1. Reset with PRESET=1 for 3 cycles mid-transmission -> TX=1, STATUS=0x005, LEVEL=0, BAUD=BAUD_RST, IRQ=0.
2. Loopback with BAUD=3, CTRL=0x03: write 0x55 then 0xA3 -> each bit lasts 64 PCLK; RXDATA reads 0x55 then 0xA3; then STATUS[2]=1 and a further read returns 0.
3. FIFO_AW=2 with TX_EN=0: write 5 bytes -> LEVEL TX=4, STATUS TX_FULL=1, TX_OVF=1. Writing 0x80 to STATUS clears TX_OVF.
4. Odd parity (CTRL=0x0F) with an injected frame carrying a bad parity bit and stop bit=0 -> byte pushed, PARITY_ERR=1, FRAMING_ERR=1. With IRQ_EN=0x4, IRQ rises 1 cycle after the flag is set.
5. RX glitch: RX low for 4 ticks -> no push, RX_EMPTY stays 1. Fill the RX FIFO past depth -> RX_OVF=1 and the original data is intact.
6. With UART_RX_TIMEOUT_EN, RXTO=4: receive 1 byte and go idle -> RX_TIMEOUT set after 4 bit periods; reading RXDATA resets the counter.

Source files
------------

// File: rtl/apb_uart_fifo_if.sv
// rtl/apb_uart_fifo_if.sv - APB3 slave bus bundle for apb_uart_fifo
interface apb_uart_fifo_if;
  logic [4:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB UART with TX/RX FIFOs; optional RX idle timeout under UART_RX_TIMEOUT_EN

module apb_uart_fifo_buf #(
  parameter int AW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  input  logic        pop_i,
  output logic [7:0]  head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wr_q, rd_q;
  logic        push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage array; contents need no reset since pointers guard validity
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end
endmodule

module apb_uart_fifo #(
  parameter int                FIFO_AW  = 4,
  parameter int                BAUD_W   = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST = '0
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_uart_fifo_if.slave apb,
  input  logic           RX,
  output logic           TX,
  output logic           IRQ
);
  localparam logic [2:0] A_TXDATA = 3'd0, A_RXDATA = 3'd1, A_BAUD  = 3'd2, A_CTRL = 3'd3,
                         A_STATUS = 3'd4, A_LEVEL  = 3'd5, A_IRQEN = 3'd6, A_RXTO = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [2:0] sel;
  logic       wr_en, rd_setup, rd_access, unused_bits;

  assign sel         = apb.PADDR[4:2];
  assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_setup    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign rd_access   = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  // Configuration registers
  logic [BAUD_W-1:0] baud_q;
  logic [4:0]        ctrl_q;
  logic [3:0]        irq_en_q;

  // Register writes from the APB access phase
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      baud_q   <= BAUD_RST;
      ctrl_q   <= '0;
      irq_en_q <= '0;
    end else if (wr_en) begin
      case (sel)
        A_BAUD:  baud_q   <= apb.PWDATA[BAUD_W-1:0];
        A_CTRL:  ctrl_q   <= apb.PWDATA[4:0];
        A_IRQEN: irq_en_q <= apb.PWDATA[3:0];
        default: ;
      endcase
    end
  end

  // Baud tick generator: one tick every baud_q+1 cycles
  logic [BAUD_W-1:0] baud_cnt_q;
  logic              tick;
  assign tick = (baud_cnt_q == '0);

  // Down-counter, reloaded immediately on a BAUD write
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                       baud_cnt_q <= BAUD_RST;
    else if (wr_en && sel == A_BAUD)  baud_cnt_q <= apb.PWDATA[BAUD_W-1:0];
    else if (tick)                    baud_cnt_q <= baud_q;
    else                              baud_cnt_q <= baud_cnt_q - 1'b1;
  end

  // FIFOs
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       tx_head, rx_head;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic [7:0]       rx_shift_q;

  assign tx_push = wr_en & (sel == A_TXDATA);
  assign rx_pop  = rd_access & (sel == A_RXDATA);

  apb_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(tx_push), .data_i(apb.PWDATA[7:0]),
    .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  apb_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(rx_push), .data_i(rx_shift_q),
    .pop_i(rx_pop), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  // Transmitter
  state_t     tx_state_q;
  logic [7:0] tx_shift_q;
  logic [2:0] tx_bit_q;
  logic [4:0] tx_tcnt_q;
  logic       tx_par_q, tx_q, tx_bit_end;

  assign tx_pop     = (tx_state_q == S_IDLE) & ctrl_q[0] & ~tx_empty;
  assign tx_bit_end = tick & (tx_tcnt_q == ((tx_state_q == S_STOP && ctrl_q[4]) ? 5'd31 : 5'd15));
  assign TX         = tx_q;

  // TX FSM; line output is registered and forced high by reset
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state_q <= S_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_tcnt_q  <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_state_q == S_IDLE) begin
      if (tx_pop) begin
        tx_state_q <= S_START;
        tx_shift_q <= tx_head;
        tx_par_q   <= (^tx_head) ^ ctrl_q[3];
        tx_tcnt_q  <= '0;
        tx_q       <= 1'b0;
      end
    end else if (tick) begin
      if (!tx_bit_end) begin
        tx_tcnt_q <= tx_tcnt_q + 1'b1;
      end else begin
        tx_tcnt_q <= '0;
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= ctrl_q[2] ? S_PARITY : S_STOP;
              tx_q       <= ctrl_q[2] ? tx_par_q : 1'b1;
            end else begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end
          S_PARITY: begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end
          default: begin
            tx_state_q <= S_IDLE;
            tx_q       <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receiver
  logic       rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_sample, rx_par_q, rx_par_bad;
  state_t     rx_state_q;
  logic [2:0] rx_bit_q;
  logic [3:0] rx_tcnt_q;

  assign rx_fall    = rx_s3_q & ~rx_s2_q;
  assign rx_sample  = tick & (rx_tcnt_q == ((rx_state_q == S_START) ? 4'd7 : 4'd15));
  assign rx_push    = (rx_state_q == S_STOP) & rx_sample & ctrl_q[1];
  assign rx_par_bad = ctrl_q[2] & (((^rx_shift_q) ^ ctrl_q[3]) != rx_par_q);

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // RX FSM: mid-bit sampling, start bit re-checked to reject glitches
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_state_q <= S_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_tcnt_q  <= '0;
      rx_par_q   <= 1'b0;
    end else if (!ctrl_q[1]) begin
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
    end else if (rx_state_q == S_IDLE) begin
      if (rx_fall) begin
        rx_state_q <= S_START;
        rx_tcnt_q  <= '0;
      end
    end else if (tick) begin
      if (!rx_sample) begin
        rx_tcnt_q <= rx_tcnt_q + 1'b1;
      end else begin
        rx_tcnt_q <= '0;
        case (rx_state_q)
          S_START: begin
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
            rx_bit_q   <= '0;
          end
          S_DATA: begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= ctrl_q[2] ? S_PARITY : S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end
          S_PARITY: begin
            rx_par_q   <= rx_s2_q;
            rx_state_q <= S_STOP;
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags, STATUS[7:4] = {TX_OVF, FRAMING_ERR, PARITY_ERR, RX_OVF}
  logic [3:0] err_q, err_set, err_clr, err_d;
  assign err_set = {tx_push & tx_full, rx_push & ~rx_s2_q, rx_push & rx_par_bad, rx_push & rx_full};
  assign err_clr = (wr_en && sel == A_STATUS) ? apb.PWDATA[7:4] : 4'b0;
  assign err_d   = (err_q & ~err_clr) | err_set;

  // Error flag register; a set in the same cycle as a clear wins
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) err_q <= '0;
    else        err_q <= err_d;
  end

  logic       rx_timeout;
  logic [7:0] rxto_rd;

`ifdef UART_RX_TIMEOUT_EN
  logic [7:0] rxto_q, to_cnt_q;
  logic [3:0] to_tick_q;
  logic       rx_to_q, to_clear, to_set;

  assign to_clear = rx_push | (rx_pop & ~rx_empty) | rx_empty;
  assign to_set   = ~to_clear & (rx_state_q == S_IDLE) & tick & (to_tick_q == 4'd15) &
                    (rxto_q != 8'd0) & (to_cnt_q + 8'd1 == rxto_q);

  // Idle bit-period counter; flag is raised once as the count reaches RXTO
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rxto_q    <= '0;
      to_cnt_q  <= '0;
      to_tick_q <= '0;
      rx_to_q   <= 1'b0;
    end else begin
      if (wr_en && sel == A_RXTO) rxto_q <= apb.PWDATA[7:0];
      if (to_clear) begin
        to_cnt_q  <= '0;
        to_tick_q <= '0;
      end else if (rx_state_q == S_IDLE && tick) begin
        to_tick_q <= to_tick_q + 1'b1;
        if (to_tick_q == 4'd15 && to_cnt_q != 8'hff) to_cnt_q <= to_cnt_q + 1'b1;
      end
      rx_to_q <= (rx_to_q & ~(wr_en && sel == A_STATUS && apb.PWDATA[9])) | to_set;
    end
  end

  assign rx_timeout = rx_to_q;
  assign rxto_rd    = rxto_q;
`else
  assign rx_timeout = 1'b0;
  assign rxto_rd    = 8'h00;
`endif

  // Interrupt: registered OR of enabled sources
  logic [3:0] irq_src;
  logic       irq_q;
  assign irq_src = {rx_timeout, |err_q, ~rx_empty, tx_empty};
  assign IRQ     = irq_q;

  // One-cycle registered interrupt output
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) irq_q <= 1'b0;
    else        irq_q <= |(irq_src & irq_en_q);
  end

  // Read data mux
  logic [31:0] rdata_d, prdata_q;
  always_comb begin
    rdata_d = '0;
    case (sel)
      A_RXDATA: rdata_d[7:0]        = rx_empty ? 8'h00 : rx_head;
      A_BAUD:   rdata_d[BAUD_W-1:0] = baud_q;
      A_CTRL:   rdata_d[4:0]        = ctrl_q;
      A_STATUS: rdata_d[9:0]        = {rx_timeout, tx_state_q != S_IDLE, err_q,
                                       rx_full, rx_empty, tx_full, tx_empty};
      A_LEVEL: begin
        rdata_d[FIFO_AW:0]       = tx_count;
        rdata_d[16+FIFO_AW:16]   = rx_count;
      end
      A_IRQEN:  rdata_d[3:0]        = irq_en_q;
      A_RXTO:   rdata_d[7:0]        = rxto_rd;
      default: ;
    endcase
  end

  // PRDATA captured in the setup phase, stable through the access phase
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)        prdata_q <= '0;
    else if (rd_setup) prdata_q <= rdata_d;
  end

  assign apb.PRDATA = prdata_q;
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - scoreboard testbench for apb_uart_fifo
module tb_apb_uart_fifo;
  localparam logic [4:0] R_TX = 5'h00, R_RX = 5'h04, R_BAUD = 5'h08, R_CTRL = 5'h0C,
                         R_STAT = 5'h10, R_LVL = 5'h14, R_IRQEN = 5'h18, R_RXTO = 5'h1C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_w, irq_w, rx_w;
  logic loop_en = 1'b0;
  logic inj = 1'b1;

  always #5 clk = ~clk;

  apb_uart_fifo_if bus();
  assign rx_w = loop_en ? tx_w : inj;

  apb_uart_fifo #(.FIFO_AW(2), .BAUD_W(16), .BAUD_RST(16'd7)) dut (
    .PCLK(clk), .PRESET(rst), .apb(bus.slave), .RX(rx_w), .TX(tx_w), .IRQ(irq_w)
  );

  int n_chk = 0;
  int n_fail = 0;
  string       exp_name[$];
  logic [31:0] exp_val[$];
  logic [31:0] exp_mask[$];

  // Scoreboard monitor: compares every APB read access phase with the queued expectation
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
      if (exp_val.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read actual=%h required=none", bus.PRDATA);
      end else begin
        string nm;
        logic [31:0] ev, em;
        nm = exp_name.pop_front();
        ev = exp_val.pop_front();
        em = exp_mask.pop_front();
        if (em != 32'h0) begin
          n_chk++;
          if ((bus.PRDATA & em) !== (ev & em)) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h mask=%h", nm, bus.PRDATA, ev, em);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.PADDR = a; bus.PWRITE = 1'b1; bus.PWDATA = d; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [4:0] a, input string nm, input logic [31:0] ev,
                        input logic [31:0] em, output logic [31:0] d);
    exp_name.push_back(nm);
    exp_val.push_back(ev);
    exp_mask.push_back(em);
    @(posedge clk); #1;
    bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    d = bus.PRDATA;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input string nm, input logic [31:0] ev, input logic [31:0] em);
    logic [31:0] d;
    apb_rd(a, nm, ev, em, d);
  endtask

  task automatic rd_peek(input logic [4:0] a, output logic [31:0] d);
    apb_rd(a, "peek", 32'h0, 32'h0, d);
  endtask

  task automatic do_reset();
    loop_en = 1'b0;
    inj = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one frame on the RX pin with 16-cycle bits (BAUD=0)
  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit, input logic sbit);
    @(posedge clk); #1;
    inj = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 inj = b[i];
      repeat (16) @(posedge clk);
    end
    if (pen) begin
      #1 inj = pbit;
      repeat (16) @(posedge clk);
    end
    #1 inj = sbit;
    repeat (16) @(posedge clk);
    #1 inj = 1'b1;
    repeat (32) @(posedge clk);
  endtask

  task automatic irq_latency();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (dut.err_q != 4'h0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("err_flag_seen", {31'b0, seen}, 32'h1);
    chk("irq_same_cycle", {31'b0, irq_w}, 32'h0);
    @(posedge clk); #1;
    chk("irq_next_cycle", {31'b0, irq_w}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt;
    bit ok;
    bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;

    // 1: reset in the middle of a transmission
    do_reset();
    apb_wr(R_CTRL, 32'h1);
    apb_wr(R_TX, 32'hAB);
    repeat (50) @(posedge clk);
    #1 chk("tx_start_bit", {31'b0, tx_w}, 32'h0);
    #1 rst = 1'b1;
    #1 chk("tx_async_reset", {31'b0, tx_w}, 32'h1);
    chk("irq_reset", {31'b0, irq_w}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd_chk(R_STAT, "status_reset", 32'h005, 32'h3FF);
    rd_chk(R_LVL, "level_reset", 32'h0, 32'hFFFFFFFF);
    rd_chk(R_BAUD, "baud_reset", 32'h7, 32'hFFFFFFFF);
    rd_chk(R_CTRL, "ctrl_reset", 32'h0, 32'hFFFFFFFF);

    // 2: loopback at BAUD=3, 64-cycle bits
    do_reset();
    loop_en = 1'b1;
    apb_wr(R_BAUD, 32'h3);
    apb_wr(R_CTRL, 32'h3);
    apb_wr(R_TX, 32'h55);
    apb_wr(R_TX, 32'hA3);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (tx_w) begin ok = 1'b1; break; end
    end
    cnt = 0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk); #1;
        cnt++;
        if (!tx_w) begin ok = 1'b1; break; end
      end
    end
    chk("bit_edges_seen", {31'b0, ok}, 32'h1);
    chk("bit_time_cycles", cnt, 32'd64);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rd_peek(R_LVL, d);
      if (d[18:16] == 3'd2) begin ok = 1'b1; break; end
    end
    chk("rx_two_bytes", {31'b0, ok}, 32'h1);
    rd_chk(R_RX, "loop_byte0", 32'h55, 32'hFFFFFFFF);
    rd_chk(R_RX, "loop_byte1", 32'hA3, 32'hFFFFFFFF);
    rd_chk(R_STAT, "loop_status", 32'h005, 32'h0FF);
    rd_chk(R_RX, "rx_empty_read", 32'h0, 32'hFFFFFFFF);

    // 3: TX FIFO overflow with transmitter disabled
    do_reset();
    for (int i = 0; i < 5; i++) apb_wr(R_TX, 32'h10 + i);
    rd_chk(R_LVL, "tx_level_full", 32'h4, 32'hFFFFFFFF);
    rd_chk(R_STAT, "tx_ovf_status", 32'h086, 32'h3FF);
    apb_wr(R_STAT, 32'h80);
    rd_chk(R_STAT, "tx_ovf_cleared", 32'h006, 32'h3FF);

    // 4: odd parity, bad parity bit and bad stop bit, error interrupt
    do_reset();
    apb_wr(R_BAUD, 32'h0);
    apb_wr(R_CTRL, 32'h0F);
    apb_wr(R_IRQEN, 32'h4);
    fork
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      irq_latency();
    join
    rd_chk(R_STAT, "par_frame_err", 32'h061, 32'h3FF);
    rd_chk(R_RX, "bad_frame_byte", 32'h3C, 32'hFFFFFFFF);
    apb_wr(R_STAT, 32'h60);
    repeat (2) @(posedge clk);
    #1 chk("irq_after_clear", {31'b0, irq_w}, 32'h0);

    // 5: glitch rejection, then RX FIFO overflow
    do_reset();
    apb_wr(R_BAUD, 32'h3);
    apb_wr(R_CTRL, 32'h2);
    @(posedge clk); #1 inj = 1'b0;
    repeat (16) @(posedge clk);
    #1 inj = 1'b1;
    repeat (200) @(posedge clk);
    rd_chk(R_STAT, "glitch_status", 32'h005, 32'h3FF);
    rd_chk(R_LVL, "glitch_level", 32'h0, 32'hFFFFFFFF);
    apb_wr(R_BAUD, 32'h0);
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
    rd_chk(R_STAT, "rx_ovf_status", 32'h019, 32'h3FF);
    rd_chk(R_LVL, "rx_level_full", 32'h40000, 32'hFFFFFFFF);
    rd_chk(R_RX, "rx_keep0", 32'h11, 32'hFFFFFFFF);
    rd_chk(R_RX, "rx_keep1", 32'h22, 32'hFFFFFFFF);
    rd_chk(R_RX, "rx_keep2", 32'h33, 32'hFFFFFFFF);
    rd_chk(R_RX, "rx_keep3", 32'h44, 32'hFFFFFFFF);

    // 6: RX idle timeout
    do_reset();
`ifdef UART_RX_TIMEOUT_EN
    apb_wr(R_BAUD, 32'h0);
    apb_wr(R_CTRL, 32'h2);
    apb_wr(R_RXTO, 32'h4);
    rd_chk(R_RXTO, "rxto_reg", 32'h4, 32'hFFFFFFFF);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (60) @(posedge clk);
    rd_chk(R_STAT, "timeout_set", 32'h200, 32'h200);
    apb_wr(R_STAT, 32'h200);
    rd_chk(R_RX, "timeout_byte", 32'h5A, 32'hFFFFFFFF);
    repeat (30) @(posedge clk);
    rd_chk(R_STAT, "timeout_restarted", 32'h000, 32'h200);
    repeat (60) @(posedge clk);
    rd_chk(R_STAT, "timeout_again", 32'h200, 32'h200);
`else
    apb_wr(R_RXTO, 32'h5);
    rd_chk(R_RXTO, "rxto_absent", 32'h0, 32'hFFFFFFFF);
    rd_chk(R_STAT, "timeout_absent", 32'h0, 32'h200);
`endif

    repeat (4) @(posedge clk);
    if (exp_val.size() != 0) chk("scoreboard_drained", exp_val.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
